// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, on-the-fly key schedule,
// valid/ready on both sides, and the ciphertext held until the consumer takes it.
module aes128_enc_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  if (NR != 10) begin : g_bad_nr
    $fatal(1, "aes128_enc_ctrl: NR must be 10");
  end

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  // Forward S-box, entry b at bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  // Byte 4c+r of the result comes from column (c+r) mod 4 of the same row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h000000};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;

  logic [127:0] sr_state;
  logic [127:0] mc_state;
  logic [127:0] rk_next;
  logic         last_round;

  assign sr_state   = shift_rows(sub_bytes(state_q));
  assign mc_state   = mix_columns(sr_state);
  assign rk_next    = key_expand(rk_q, rcon(round_q));
  assign last_round = (round_q == 4'(NR));

  // Round sequencing and next-state datapath selection.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          fsm_d   = StRound;
          state_d = in_data ^ in_key;
          rk_d    = in_key;
          round_d = 4'd1;
        end
      end
      StRound: begin
        rk_d = rk_next;
        if (last_round) begin
          state_d = sr_state ^ rk_next;
          fsm_d   = StDone;
        end else begin
          state_d = mc_state ^ rk_next;
          round_d = round_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          fsm_d   = StIdle;
          round_d = 4'd0;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State, key and round registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
    end
  end

  // Ready is held low while reset is asserted even though the FSM sits in idle.
  assign in_ready  = (fsm_q == StIdle) && rst_n;
  assign out_valid = (fsm_q == StDone);
  assign out_data  = out_valid ? state_q : '0;
  assign busy      = (fsm_q != StIdle);
  assign round     = round_q;

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Self-checking bench for aes128_enc_ctrl: FIPS-197 vectors, backpressure, busy rejection,
// mid-job reset and randomized streaming against a byte-array AES model.
module tb_aes128_enc_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_enc_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model: GF(2^8) arithmetic on byte arrays ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (a^254) then the affine map.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [31:0] w[44];
    logic [31:0] tw;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {ref_sbox(tw[31:24]), ref_sbox(tw[23:16]), ref_sbox(tw[15:8]), ref_sbox(tw[7:0])};
        tw = tw ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = ref_sbox(s[k]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int k = 0; k < 16; k++) s[k] = t[k];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            t[4*c+r] = gmul(s[4*c+r], 8'h02) ^ gmul(s[4*c+(r+1)%4], 8'h03)
                     ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
          end
        end
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd0);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_out_data"}, out_data, 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_round"}, 128'(round), 128'd0);
  endtask

  // Accept one job (in_ready must already be high), returning cycles until out_valid.
  task automatic accept_and_wait(input logic [127:0] pt, input logic [127:0] key,
                                 output int lat);
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int n;
    int nv;
    int acc_prev;
    logic [127:0] pt, key, exp_ct;

    // Reset state while rst_n is low
    #2;
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 C.1 with 10-cycle latency, then 20 cycles of backpressure
    accept_and_wait(C1_PT, C1_KEY, lat);
    check("c1_latency", 128'(lat), 128'd10);
    check("c1_out_data", out_data, C1_CT);
    check("c1_round_done", 128'(round), 128'd10);
    check("c1_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_data", out_data, C1_CT);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_release_out_data", out_data, 128'd0);
    check("bp_release_round", 128'(round), 128'd0);

    // FIPS-197 B with round stepping; out_ready held high early must not matter
    out_ready = 1'b1;
    in_data   = B_PT;
    in_key    = B_KEY;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check("b_round_1", 128'(round), 128'd1);
    check("b_out_valid_early", 128'(out_valid), 128'd0);
    for (int k = 2; k <= 10; k++) begin
      step();
      check("b_round_step", 128'(round), 128'(k));
      check("b_not_done", 128'(out_valid), 128'd0);
    end
    step();
    check("b_out_valid", 128'(out_valid), 128'd1);
    check("b_out_data", out_data, B_CT);
    check("b_round_done", 128'(round), 128'd10);
    step();
    check("b_done_clears", 128'(out_valid), 128'd0);
    check("b_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b0;

    // Busy rejection: inputs scrambled every cycle after the accept edge
    pt     = rand128();
    key    = rand128();
    exp_ct = ref_aes(pt, key);
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    step();
    n = 0;
    while (!out_valid && n < 30) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand128();
      in_key   = rand128();
      step();
      n++;
    end
    check("busy_latency", 128'(n), 128'd10);
    check("busy_out_data", out_data, exp_ct);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      step();
      check("busy_hold_data", out_data, exp_ct);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) nv++;
    end
    check("busy_no_extra_valid", 128'(nv), 128'd0);
    check("busy_idle_ready", 128'(in_ready), 128'd1);

    // Mid-job reset at round 5, then a clean C.1 job
    in_data  = C1_PT;
    in_key   = C1_KEY;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (round != 4'd5 && n < 20) begin
      step();
      n++;
    end
    check("midrst_reached_r5", 128'(round), 128'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_release_ready", 128'(in_ready), 128'd1);
    accept_and_wait(C1_PT, C1_KEY, lat);
    check("midrst_c1_latency", 128'(lat), 128'd10);
    check("midrst_c1_data", out_data, C1_CT);
    out_ready = 1'b1;
    step();

    // Streaming: 8 random jobs, out_ready tied high, 12 cycles between accepts
    acc_prev = 0;
    for (int i = 0; i < 8; i++) begin
      pt     = rand128();
      key    = rand128();
      exp_ct = ref_aes(pt, key);
      in_data  = pt;
      in_key   = key;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
        step();
        n++;
      end
      step();
      in_valid = 1'b0;
      if (i > 0) check("stream_spacing", 128'(cyc - acc_prev), 128'd12);
      acc_prev = cyc;
      n = 0;
      while (!out_valid && n < 30) begin
        step();
        n++;
      end
      check("stream_out_valid", 128'(out_valid), 128'd1);
      check("stream_out_data", out_data, exp_ct);
    end
    step();
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
